spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth for spi_cs/spi_sclk/spi_mosi.
REQ-002 SHALL have parameter IDLE_BYTE, default 8'hFF, the byte shifted out when no TX data is pending.
REQ-003 clk  input  1  system clock; one clock only.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 spi_cs  input  1  chip select, active-low, asynchronous to clk.
REQ-006 spi_sclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-007 spi_mosi  input  1  serial data in, MSB first.
REQ-008 spi_miso  output  1  serial data out, MSB first.
REQ-009 spi_miso_oe  output  1  high while the synchronized spi_cs is low; board drives Z otherwise.
REQ-010 tx_data/tx_valid/tx_ready  in/in/out  8/1/1  next response byte, valid/ready handshake.
REQ-011 rx_data/rx_valid/rx_ready  out/out/in  8/1/1  received byte, valid/ready handshake.
REQ-012 overrun  output  1  sticky flag: a received byte was dropped.
REQ-013 frame_end  output  1  one-cycle pulse when spi_cs deasserts.

Function
REQ-014 SHALL operate correctly for f(spi_sclk) <= f(clk)/8; all SPI inputs pass through SYNC_STAGES flops before use.
REQ-015 SHALL implement states IDLE (cs high), LOAD (one cycle after cs falls), SHIFT.
REQ-016 IDLE->LOAD on synchronized cs falling; LOAD->SHIFT unconditionally; any state->IDLE on synchronized cs high.
REQ-017 In LOAD, SHALL load the TX shift register from the holding register if full (consuming it), else from IDLE_BYTE, and SHALL drive bit 7 on spi_miso.
REQ-018 SHALL sample spi_mosi on each detected sclk rising edge into the RX shift register; bit counter 0..7 wraps to 0 after the 8th bit.
REQ-019 SHALL advance spi_miso to the next bit on each detected sclk falling edge; after the 8th rising edge the next byte is loaded per REQ-017 and its MSB driven on the following falling edge.
REQ-020 On the 8th rising edge, if rx_valid is low, SHALL present the byte on rx_data with rx_valid high on the next cycle.
REQ-021 On the 8th rising edge, if rx_valid is high and rx_ready low in that cycle, SHALL drop the new byte and set overrun; if rx_ready is high in that same cycle, SHALL accept the new byte without overrun.
REQ-022 rx_valid SHALL stay high with rx_data stable until rx_valid & rx_ready.
REQ-023 tx_ready SHALL be high exactly when the one-entry holding register is empty; transfer on tx_valid & tx_ready; a simultaneous load and write in the same cycle SHALL leave the register full with the new byte.
REQ-024 cs rising mid-byte SHALL discard the partial RX byte and the in-flight TX byte, zero the bit counter, keep the holding register, and pulse frame_end.
REQ-025 overrun SHALL be cleared only by rst.

Reset
REQ-026 On rst: state IDLE, counters 0, holding register empty, synchronizers set to cs=1, sclk=0, mosi=0.
REQ-027 Reset outputs: spi_miso=1, spi_miso_oe=0, tx_ready=1, rx_valid=0, rx_data=0, overrun=0, frame_end=0.
REQ-028 rst asserted mid-frame SHALL abort the frame, with no rx_valid and no frame_end.

Configuration
REQ-029 Macro SPI_SLAVE_ECHO_EN: when defined, a load with an empty holding register SHALL use the last completely received byte (0x00 after reset) instead of IDLE_BYTE.
REQ-030 Without SPI_SLAVE_ECHO_EN, SHALL behave per REQ-017 and contain no echo register.

Structure
REQ-031 Package spi_slave_pkg SHALL hold the state enum type and the bit-counter width constant (3).
REQ-032 Sub-module spi_sync SHALL perform synchronization and rising/falling-edge detection for the three SPI inputs.

Verification
REQ-033 Preload tx 0xA5; frame of 1 byte, mosi 0x3C -> miso 0xA5, rx_data 0x3C, frame_end pulse.
REQ-034 No tx data; 2-byte frame mosi 0x01,0x02 -> miso 0xFF,0xFF (echo build: 0x00,0x01).
REQ-035 rx_ready held low; 3-byte frame -> rx_data holds byte 1, overrun=1 after byte 2.
REQ-036 cs raised after 4 bits of 0xF0, then a new frame with mosi 0x55 -> only 0x55 received, bit count restarts.
REQ-037 rst pulsed mid-byte -> all outputs at REQ-027 values the next cycle, no rx_valid.
REQ-038 sclk at clk/8 with tx_valid written in the cycle the holding register is consumed -> no byte lost or duplicated across 4 bytes.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI mode-0 slave.
// The state enum gives the encoding; the FSM itself uses the plain localparam aliases.
package spi_slave_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_LOAD  = LOAD;
    localparam logic [1:0] ST_SHIFT = SHIFT;

    localparam int BIT_CNT_W = 3;

endpackage

// File: rtl/spi_sync.sv
// Synchronizes spi_cs/spi_sclk/spi_mosi into the clk domain.
// Also produces single-cycle edge strobes for cs and sclk.
module spi_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_cs,
    input  logic spi_sclk,
    input  logic spi_mosi,
    output logic cs,
    output logic mosi,
    output logic cs_rise,
    output logic cs_fall,
    output logic sclk_rise,
    output logic sclk_fall
);
    import spi_slave_pkg::*;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   cs_d;
    logic                   sclk_d;
    logic                   sclk;

    // Reset values model an idle bus: deselected, clock low.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_d      <= 1'b1;
            sclk_d    <= 1'b0;
        end else begin
            cs_sync   <= (cs_sync << 1)   | SYNC_STAGES'(spi_cs);
            sclk_sync <= (sclk_sync << 1) | SYNC_STAGES'(spi_sclk);
            mosi_sync <= (mosi_sync << 1) | SYNC_STAGES'(spi_mosi);
            cs_d      <= cs;
            sclk_d    <= sclk;
        end
    end

    assign cs        = cs_sync[SYNC_STAGES-1];
    assign sclk      = sclk_sync[SYNC_STAGES-1];
    assign mosi      = mosi_sync[SYNC_STAGES-1];
    assign cs_rise   = cs & ~cs_d;
    assign cs_fall   = ~cs & cs_d;
    assign sclk_rise = sclk & ~sclk_d;
    assign sclk_fall = ~sclk & sclk_d;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave with one-entry TX holding register and RX valid/ready output.
// Define SPI_SLAVE_ECHO_EN to answer with the last received byte instead of IDLE_BYTE.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_cs,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       overrun,
    output logic       frame_end
);

    logic                 cs;
    logic                 mosi;
    logic                 cs_rise;
    logic                 cs_fall;
    logic                 sclk_rise;
    logic                 sclk_fall;

    logic [1:0]           state;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [6:0]           rx_shift;
    logic [7:0]           tx_shift;
    logic                 msb_pending;
    logic                 miso_q;
    logic                 hold_full;
    logic [7:0]           hold_data;

    logic                 byte_done;
    logic                 load_now;
    logic [7:0]           rx_byte;
    logic [7:0]           fill_byte;
    logic [7:0]           next_tx;

    spi_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .spi_cs    (spi_cs),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .cs        (cs),
        .mosi      (mosi),
        .cs_rise   (cs_rise),
        .cs_fall   (cs_fall),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall)
    );

    assign rx_byte   = {rx_shift, mosi};
    assign byte_done = (state == ST_SHIFT) && !cs && sclk_rise && (bit_cnt == '1);
    assign load_now  = ((state == ST_LOAD) && !cs) || byte_done;
    assign next_tx   = hold_full ? hold_data : fill_byte;

`ifdef SPI_SLAVE_ECHO_EN
    logic [7:0] echo_byte;

    // The byte completing this very cycle counts as the last received one.
    assign fill_byte = byte_done ? rx_byte : echo_byte;

    always_ff @(posedge clk) begin
        if (rst)
            echo_byte <= 8'h00;
        else if (byte_done)
            echo_byte <= rx_byte;
    end
`else
    assign fill_byte = IDLE_BYTE;
`endif

    // Deselect wins over everything and drops any partial byte in both directions.
    always_ff @(posedge clk) begin
        if (rst || cs) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            msb_pending <= 1'b0;
            miso_q      <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cs_fall)
                        state <= ST_LOAD;
                end
                ST_LOAD: begin
                    state    <= ST_SHIFT;
                    tx_shift <= next_tx;
                    miso_q   <= next_tx[7];
                end
                ST_SHIFT: begin
                    if (sclk_rise) begin
                        rx_shift <= rx_byte[6:0];
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (byte_done) begin
                            tx_shift    <= next_tx;
                            msb_pending <= 1'b1;
                        end
                    end else if (sclk_fall) begin
                        // A freshly loaded byte puts its MSB out instead of shifting.
                        if (msb_pending) begin
                            miso_q      <= tx_shift[7];
                            msb_pending <= 1'b0;
                        end else begin
                            miso_q   <= tx_shift[6];
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A write in the same cycle as a load overrides the consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold_data <= 8'h00;
        end else begin
            if (load_now && hold_full)
                hold_full <= 1'b0;
            if (tx_valid && tx_ready) begin
                hold_full <= 1'b1;
                hold_data <= tx_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
            if (byte_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= rx_byte;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            frame_end <= 1'b0;
        else
            frame_end <= cs_rise && (state != ST_IDLE);
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = ~cs;
    assign tx_ready    = ~hold_full;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: an SPI mode-0 master at clk/8 plus rx/frame_end monitors.
// Expected MISO bytes follow SPI_SLAVE_ECHO_EN when it is defined.
module tb_spi_slave;

    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_cs;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       overrun;
    logic       frame_end;

    int         tests_run = 0;
    int         tests_failed = 0;
    int         fe_cnt = 0;
    logic [7:0] rx_q[$];

    logic [7:0] m0, m1, m2;
    logic [7:0] mi[4];
    logic [7:0] mo[4];
    logic [7:0] exp_tx[4];
    logic [7:0] feed[3];
    int         fe0;

    spi_slave dut (
        .clk         (clk),
        .rst         (rst),
        .spi_cs      (spi_cs),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .overrun     (overrun),
        .frame_end   (frame_end)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_end)
            fe_cnt++;
        if (!rst && rx_valid && rx_ready)
            rx_q.push_back(rx_data);
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic spi_byte(input logic [7:0] out_byte, output logic [7:0] in_byte);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = out_byte[i];
            #HALF;
            in_byte[i] = spi_miso;
            spi_sclk = 1'b1;
            #HALF;
            spi_sclk = 1'b0;
        end
    endtask

    task automatic cs_begin();
        @(negedge clk);
        spi_cs = 1'b0;
        #100;
    endtask

    task automatic cs_end();
        #HALF;
        spi_cs = 1'b1;
        #100;
        repeat (4) @(negedge clk);
    endtask

    task automatic write_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; spi_cs = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (spi_miso !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_miso: got %b expected 1", spi_miso); end
        tests_run++;
        if (spi_miso_oe !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_oe: got %b expected 0", spi_miso_oe); end
        tests_run++;
        if (tx_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_tx_ready: got %b expected 1", tx_ready); end
        tests_run++;
        if (rx_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        tests_run++;
        if (rx_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_rx_data: got %h expected 00", rx_data); end
        tests_run++;
        if (overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
        tests_run++;
        if (frame_end !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_frame_end: got %b expected 0", frame_end); end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_idle_byte();
        logic [7:0] e0, e1;
`ifdef SPI_SLAVE_ECHO_EN
        e0 = 8'h00; e1 = 8'h01;
`else
        e0 = 8'hFF; e1 = 8'hFF;
`endif
        rx_ready = 1'b1;
        rx_q.delete();
        cs_begin();
        spi_byte(8'h01, m0);
        spi_byte(8'h02, m1);
        cs_end();
        tests_run++;
        if (m0 !== e0) begin tests_failed++; $display("[TB] FAIL idle_miso0: got %h expected %h", m0, e0); end
        tests_run++;
        if (m1 !== e1) begin tests_failed++; $display("[TB] FAIL idle_miso1: got %h expected %h", m1, e1); end
        tests_run++;
        if (rx_q.size() !== 2) begin
            tests_failed++; $display("[TB] FAIL idle_rx_count: got %0d expected 2", rx_q.size());
        end else if (rx_q[0] !== 8'h01 || rx_q[1] !== 8'h02) begin
            tests_failed++; $display("[TB] FAIL idle_rx_bytes: got %h %h expected 01 02", rx_q[0], rx_q[1]);
        end
        tests_run++;
        if (overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_overrun: got %b expected 0", overrun); end
        rx_ready = 1'b0;
    endtask

    task automatic test_single_byte();
        write_tx(8'hA5);
        tests_run++;
        if (tx_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_tx_full: got %b expected 0", tx_ready); end
        fe0 = fe_cnt;
        cs_begin();
        tests_run++;
        if (spi_miso_oe !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_oe_on: got %b expected 1", spi_miso_oe); end
        spi_byte(8'h3C, m0);
        cs_end();
        tests_run++;
        if (m0 !== 8'hA5) begin tests_failed++; $display("[TB] FAIL single_miso: got %h expected a5", m0); end
        tests_run++;
        if (rx_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_rx_valid: got %b expected 1", rx_valid); end
        tests_run++;
        if (rx_data !== 8'h3C) begin tests_failed++; $display("[TB] FAIL single_rx_data: got %h expected 3c", rx_data); end
        tests_run++;
        if (fe_cnt !== fe0 + 1) begin tests_failed++; $display("[TB] FAIL single_frame_end: got %0d pulses expected 1", fe_cnt - fe0); end
        tests_run++;
        if (tx_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_tx_empty: got %b expected 1", tx_ready); end
        tests_run++;
        if (spi_miso_oe !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_oe_off: got %b expected 0", spi_miso_oe); end
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        tests_run++;
        if (rx_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_rx_consumed: got %b expected 0", rx_valid); end
    endtask

    task automatic test_abort();
        logic [7:0] e;
`ifdef SPI_SLAVE_ECHO_EN
        e = 8'h3C;
`else
        e = 8'hFF;
`endif
        rx_ready = 1'b1;
        rx_q.delete();
        fe0 = fe_cnt;
        cs_begin();
        for (int i = 0; i < 4; i++) begin
            spi_mosi = 1'b1;
            #HALF;
            spi_sclk = 1'b1;
            #HALF;
            spi_sclk = 1'b0;
        end
        cs_end();
        tests_run++;
        if (fe_cnt !== fe0 + 1) begin tests_failed++; $display("[TB] FAIL abort_frame_end: got %0d pulses expected 1", fe_cnt - fe0); end
        tests_run++;
        if (rx_q.size() !== 0) begin tests_failed++; $display("[TB] FAIL abort_no_rx: got %0d bytes expected 0", rx_q.size()); end
        cs_begin();
        spi_byte(8'h55, m0);
        cs_end();
        tests_run++;
        if (rx_q.size() !== 1) begin
            tests_failed++; $display("[TB] FAIL abort_rx_count: got %0d expected 1", rx_q.size());
        end else if (rx_q[0] !== 8'h55) begin
            tests_failed++; $display("[TB] FAIL abort_rx_byte: got %h expected 55", rx_q[0]);
        end
        tests_run++;
        if (m0 !== e) begin tests_failed++; $display("[TB] FAIL abort_miso: got %h expected %h", m0, e); end
        rx_ready = 1'b0;
    endtask

    task automatic test_overrun();
        rx_ready = 1'b0;
        cs_begin();
        spi_byte(8'h11, m0);
        @(negedge clk);
        tests_run++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
            tests_failed++; $display("[TB] FAIL ovr_byte1: got v=%b d=%h expected v=1 d=11", rx_valid, rx_data);
        end
        tests_run++;
        if (overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovr_not_yet: got %b expected 0", overrun); end
        spi_byte(8'h22, m1);
        @(negedge clk);
        tests_run++;
        if (overrun !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovr_set: got %b expected 1", overrun); end
        spi_byte(8'h33, m2);
        cs_end();
        tests_run++;
        if (rx_data !== 8'h11) begin tests_failed++; $display("[TB] FAIL ovr_rx_held: got %h expected 11", rx_data); end
        tests_run++;
        if (rx_valid !== 1'b1 || overrun !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL ovr_sticky: got v=%b o=%b expected v=1 o=1", rx_valid, overrun);
        end
    endtask

    task automatic test_reset_mid();
        fe0 = fe_cnt;
        cs_begin();
        for (int i = 0; i < 4; i++) begin
            spi_mosi = i[0];
            #HALF;
            spi_sclk = 1'b1;
            #HALF;
            spi_sclk = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        spi_cs = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (spi_miso !== 1'b1 || spi_miso_oe !== 1'b0 || tx_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL rstmid_tx_side: got miso=%b oe=%b ready=%b expected 1 0 1", spi_miso, spi_miso_oe, tx_ready);
        end
        tests_run++;
        if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
            tests_failed++; $display("[TB] FAIL rstmid_rx_side: got v=%b d=%h expected 0 00", rx_valid, rx_data);
        end
        tests_run++;
        if (overrun !== 1'b0 || frame_end !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL rstmid_flags: got o=%b fe=%b expected 0 0", overrun, frame_end);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        tests_run++;
        if (rx_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_no_rx: got %b expected 0", rx_valid); end
        tests_run++;
        if (fe_cnt !== fe0) begin tests_failed++; $display("[TB] FAIL rstmid_no_frame_end: got %0d pulses expected 0", fe_cnt - fe0); end
    endtask

    task automatic test_back_to_back();
        int wait_cnt;
        mo[0] = 8'hC1; mo[1] = 8'hC2; mo[2] = 8'hC3; mo[3] = 8'hC4;
        exp_tx[0] = 8'h10; exp_tx[1] = 8'h20; exp_tx[2] = 8'h30; exp_tx[3] = 8'h40;
        feed[0] = 8'h20; feed[1] = 8'h30; feed[2] = 8'h40;
        rx_ready = 1'b1;
        rx_q.delete();
        write_tx(8'h10);
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    tx_data  = feed[k];
                    tx_valid = 1'b1;
                    wait_cnt = 0;
                    @(negedge clk);
                    while (!tx_ready && wait_cnt < 2000) begin
                        @(negedge clk);
                        wait_cnt++;
                    end
                    tests_run++;
                    if (tx_ready !== 1'b1) begin
                        tests_failed++; $display("[TB] FAIL b2b_tx_wait%0d: got ready=%b expected 1", k, tx_ready);
                    end
                    @(posedge clk);
                    #1;
                end
                tx_valid = 1'b0;
            end
            begin
                cs_begin();
                for (int j = 0; j < 4; j++)
                    spi_byte(mo[j], mi[j]);
                cs_end();
            end
        join
        for (int j = 0; j < 4; j++) begin
            tests_run++;
            if (mi[j] !== exp_tx[j]) begin
                tests_failed++; $display("[TB] FAIL b2b_miso%0d: got %h expected %h", j, mi[j], exp_tx[j]);
            end
        end
        tests_run++;
        if (rx_q.size() !== 4) begin
            tests_failed++; $display("[TB] FAIL b2b_rx_count: got %0d expected 4", rx_q.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                if (rx_q[j] !== mo[j]) begin
                    tests_failed++; $display("[TB] FAIL b2b_rx%0d: got %h expected %h", j, rx_q[j], mo[j]);
                end
            end
        end
        tests_run++;
        if (tx_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_hold_empty: got %b expected 1", tx_ready); end
        rx_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_byte();
        test_single_byte();
        test_abort();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
